// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Holds the FSM state enum, datapath widths and queue entry layout.
package fetch_pkg;

    localparam int PC_W   = 64;
    localparam int INST_W = 32;

    localparam logic [PC_W-1:0] PC_INC = 64'd4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        HOLD
    } state_t;

    typedef struct packed {
        logic [INST_W-1:0] inst;
        logic [PC_W-1:0]   pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// Small FIFO of fetched {inst, pc} entries with synchronous flush.
// Ports: clk, rst_n, push/wr_entry, pop, flush, head, full, empty, count.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  fetch_entry_t wr_entry,
    input  logic         pop,
    input  logic         flush,
    output fetch_entry_t head,
    output logic         full,
    output logic         empty,
    output logic [CW-1:0] count
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t    mem [DEPTH];
    logic [PW-1:0]   rd_ptr;
    logic [PW-1:0]   wr_ptr;
    logic            pop_ok;
    logic            push_ok;

    function automatic logic [PW-1:0] inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign pop_ok  = pop && !empty;
    // a full queue still accepts a push when the head leaves this cycle
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= wr_entry;
                wr_ptr      <= inc(wr_ptr);
            end
            if (pop_ok) begin
                rd_ptr <= inc(rd_ptr);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: waits RD_LAT cycles per fetch, queues results.
// Ports: CLK, Reset_L, en, imem_addr/imem_data, redirect/redirect_pc, inst handshake.
module fetch_sequencer
    import fetch_pkg::*;
#(
    parameter int              RD_LAT   = 2,
    parameter logic [PC_W-1:0] START_PC = 64'h0,
    parameter int              QDEPTH   = 2
) (
    input  logic              CLK,
    input  logic              Reset_L,
    input  logic              en,
    output logic [PC_W-1:0]   imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              redirect,
    input  logic [PC_W-1:0]   redirect_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic [INST_W-1:0] inst,
    output logic [PC_W-1:0]   inst_pc
);

    localparam int         CW   = $clog2(QDEPTH + 1);
    localparam logic [3:0] LAST = 4'(RD_LAT - 1);

    state_t          state;
    state_t          state_n;
    logic [PC_W-1:0] fetch_pc;
    logic [PC_W-1:0] pc_n;
    logic [3:0]      cnt;
    logic [3:0]      cnt_n;

    logic            pop;
    logic            push;
    logic            space;
    logic            full;
    logic            empty;
    logic [CW-1:0]   count;
    fetch_entry_t    head;
    fetch_entry_t    wr_entry;

    assign imem_addr  = fetch_pc;
    assign inst_valid = !empty;
    assign inst       = head.inst;
    assign inst_pc    = head.pc;
    assign pop        = inst_valid && inst_ready;
    assign space      = !full || pop;
    assign wr_entry   = '{inst: imem_data, pc: fetch_pc};

    always_ff @(posedge CLK or negedge Reset_L) begin
        if (!Reset_L) begin
            state    <= IDLE;
            fetch_pc <= START_PC;
            cnt      <= '0;
        end else begin
            state    <= state_n;
            fetch_pc <= pc_n;
            cnt      <= cnt_n;
        end
    end

    always_comb begin
        state_n = state;
        pc_n    = fetch_pc;
        cnt_n   = cnt;
        push    = 1'b0;
        if (redirect) begin
            state_n = WAIT;
            pc_n    = {redirect_pc[PC_W-1:2], 2'b00};
            cnt_n   = '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (en) begin
                        state_n = WAIT;
                        cnt_n   = '0;
                    end
                end
                WAIT: begin
                    if (cnt == LAST) begin
                        if (space) begin
                            push    = 1'b1;
                            pc_n    = fetch_pc + PC_INC;
                            cnt_n   = '0;
                            state_n = en ? WAIT : IDLE;
                        end else begin
                            state_n = HOLD;
                        end
                    end else begin
                        cnt_n = cnt + 4'd1;
                    end
                end
                HOLD: begin
                    // address is still held, so imem_data is still valid
                    if (pop) begin
                        push    = 1'b1;
                        pc_n    = fetch_pc + PC_INC;
                        cnt_n   = '0;
                        state_n = en ? WAIT : IDLE;
                    end
                end
                default: state_n = IDLE;
            endcase
        end
    end

    fetch_queue #(
        .DEPTH(QDEPTH)
    ) u_queue (
        .clk     (CLK),
        .rst_n   (Reset_L),
        .push    (push),
        .wr_entry(wr_entry),
        .pop     (pop),
        .flush   (redirect),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .count   (count)
    );

    a_count_bound : assert property (
        @(posedge CLK) disable iff (!Reset_L) count <= CW'(QDEPTH)
    );

endmodule
